// File: rtl/apx_pipe_adder_if.sv
// Operand/result handshake bundle for apx_pipe_adder.
// The master drives operands and out_ready; the slave is the adder.
interface apx_pipe_adder_if #(
  parameter int N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         approx_en;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         cout;

  modport master (
    output in_valid, A, B, approx_en, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, A, B, approx_en, out_ready,
    output in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/apx_pipe_adder.sv
// S-stage pipelined lower-part-OR approximate adder (K OR-ed LSBs, exact upper part).
// Optional macro APX_ERR_STATS_EN adds an exact-sum shadow pipe and error statistics.
module apx_pipe_adder #(
  parameter int N = 8,
  parameter int K = 4,
  parameter int S = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  apx_pipe_adder_if.slave      bus,
  input  logic                 stat_clr,
  output logic [15:0]          err_cnt,
  output logic [31:0]          err_sum
);

  // LOW_TOP marks bit K-1, the source of the carry into the exact part (zero when K=0).
  localparam logic [N-1:0] LOW_MASK = {N{1'b1}} >> (N - K);
  localparam logic [N-1:0] LOW_TOP  = LOW_MASK ^ (LOW_MASK >> 1);

  logic         advance_s;
  logic         carry_in_s;
  logic [N:0]   exact_s;
  logic [N:0]   approx_hi_s;
  logic [N:0]   result_s;
  logic [S-1:0] valid_r;
  logic [N:0]   res_r [S];

  // Stage-0 arithmetic: exact sum and approximate sum, chosen by approx_en.
  always_comb begin
    carry_in_s  = |(bus.A & bus.B & LOW_TOP);
    exact_s     = {1'b0, bus.A} + {1'b0, bus.B};
    approx_hi_s = {1'b0, bus.A & ~LOW_MASK} + {1'b0, bus.B & ~LOW_MASK}
                + ((N+1)'(carry_in_s) << K);
    if (bus.approx_en) begin
      result_s = approx_hi_s | {1'b0, (bus.A | bus.B) & LOW_MASK};
    end else begin
      result_s = exact_s;
    end
  end

  assign advance_s     = !valid_r[S-1] | bus.out_ready;
  assign bus.in_ready  = advance_s;
  assign bus.out_valid = valid_r[S-1];
  assign bus.sum       = res_r[S-1][N-1:0];
  assign bus.cout      = res_r[S-1][N];

  // Result pipeline: everything shifts together on advance, bubbles included.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= {S{1'b0}};
      for (int i = 0; i < S; i++) begin
        res_r[i] <= {(N+1){1'b0}};
      end
    end else if (advance_s) begin
      valid_r[0] <= bus.in_valid;
      res_r[0]   <= result_s;
      for (int i = 1; i < S; i++) begin
        valid_r[i] <= valid_r[i-1];
        res_r[i]   <= res_r[i-1];
      end
    end
  end

`ifdef APX_ERR_STATS_EN
  logic [N:0]  exact_r [S];
  logic [15:0] err_cnt_r;
  logic [31:0] err_sum_r;
  logic        out_xfer_s;
  logic        mismatch_s;
  logic [N:0]  dist_s;
  logic [32:0] sum_next_s;

  // Shadow pipe carrying the exact sum alongside each result.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < S; i++) begin
        exact_r[i] <= {(N+1){1'b0}};
      end
    end else if (advance_s) begin
      exact_r[0] <= exact_s;
      for (int i = 1; i < S; i++) begin
        exact_r[i] <= exact_r[i-1];
      end
    end
  end

  // Error distance of the result currently at the output.
  always_comb begin
    out_xfer_s = valid_r[S-1] & bus.out_ready;
    mismatch_s = exact_r[S-1] != res_r[S-1];
    if (exact_r[S-1] >= res_r[S-1]) begin
      dist_s = exact_r[S-1] - res_r[S-1];
    end else begin
      dist_s = res_r[S-1] - exact_r[S-1];
    end
    sum_next_s = {1'b0, err_sum_r} + 33'(dist_s);
  end

  // Saturating statistics; a clear beats a concurrent output transfer.
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      err_cnt_r <= 16'h0000;
      err_sum_r <= 32'h0000_0000;
    end else if (out_xfer_s && mismatch_s) begin
      if (err_cnt_r != 16'hFFFF) begin
        err_cnt_r <= err_cnt_r + 16'd1;
      end
      err_sum_r <= sum_next_s[32] ? 32'hFFFF_FFFF : sum_next_s[31:0];
    end
  end

  assign err_cnt = err_cnt_r;
  assign err_sum = err_sum_r;
`else
  logic stat_clr_unused_s;
  assign stat_clr_unused_s = stat_clr;
  assign err_cnt           = 16'h0000;
  assign err_sum           = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_apx_pipe_adder.sv
// Directed, table-driven bench for apx_pipe_adder (N=8, K=4, S=2).
// Error-statistics expectations become zero when APX_ERR_STATS_EN is not defined.
module tb_apx_pipe_adder;
  localparam int N = 8;
  localparam int K = 4;
  localparam int S = 2;
`ifdef APX_ERR_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       m;
    logic [7:0] s;
    logic       c;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stat_clr;
  logic [15:0] err_cnt;
  logic [31:0] err_sum;
  logic [15:0] mdl_cnt;
  logic [31:0] mdl_sum;
  int          n_checks = 0;
  int          n_fail = 0;
  vec_t        vecs [8];

  apx_pipe_adder_if #(.N(N)) bus ();

  apx_pipe_adder #(.N(N), .K(K), .S(S)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .stat_clr (stat_clr),
    .err_cnt  (err_cnt),
    .err_sum  (err_sum)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] ref_add(input logic [7:0] a, input logic [7:0] b, input logic m);
    logic [4:0] hi;
    if (!m) return {1'b0, a} + {1'b0, b};
    hi = {1'b0, a[7:4]} + {1'b0, b[7:4]} + {4'b0000, a[3] & b[3]};
    return {hi, a[3:0] | b[3:0]};
  endfunction

  task automatic account(input logic [7:0] a, input logic [7:0] b, input logic m);
    logic [8:0] ex;
    logic [8:0] ap;
    ex = {1'b0, a} + {1'b0, b};
    ap = ref_add(a, b, m);
    if (ex != ap) begin
      if (mdl_cnt != 16'hFFFF) mdl_cnt = mdl_cnt + 16'd1;
      mdl_sum = mdl_sum + ((ex > ap) ? 32'(ex - ap) : 32'(ap - ex));
    end
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_err_cnt"}, 64'(err_cnt), STATS_ON ? 64'(mdl_cnt) : 64'd0);
    check({tag, "_err_sum"}, 64'(err_sum), STATS_ON ? 64'(mdl_sum) : 64'd0);
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic m);
    bus.in_valid  = v;
    bus.A         = a;
    bus.B         = b;
    bus.approx_en = m;
  endtask

  // One isolated transaction; starts and ends just after a falling edge.
  task automatic run_one(input vec_t v, input int idx);
    drive(1'b1, v.a, v.b, v.m);
    @(negedge clk);
    drive(1'b0, 8'h00, 8'h00, ~v.m);
    check($sformatf("v%0d_early_valid", idx), 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    check($sformatf("v%0d_valid", idx), 64'(bus.out_valid), 64'd1);
    check($sformatf("v%0d_sum", idx), 64'(bus.sum), 64'(v.s));
    check($sformatf("v%0d_cout", idx), 64'(bus.cout), 64'(v.c));
    @(negedge clk);
    account(v.a, v.b, v.m);
    check($sformatf("v%0d_drained", idx), 64'(bus.out_valid), 64'd0);
    check_stats($sformatf("v%0d", idx));
  endtask

  initial begin
    vecs[0] = '{8'h0F, 8'h01, 1'b1, 8'h0F, 1'b0};
    vecs[1] = '{8'h38, 8'h18, 1'b1, 8'h58, 1'b0};
    vecs[2] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[3] = '{8'hF0, 8'h20, 1'b1, 8'h10, 1'b1};
    vecs[4] = '{8'h0A, 8'h05, 1'b1, 8'h0F, 1'b0};
    vecs[5] = '{8'h88, 8'h88, 1'b1, 8'h18, 1'b1};
    vecs[6] = '{8'h77, 8'h33, 1'b0, 8'hAA, 1'b0};
    vecs[7] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    mdl_cnt = 16'h0000;
    mdl_sum = 32'h0000_0000;

    rst = 1'b1;
    stat_clr = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_sum", 64'(bus.sum), 64'd0);
    check("rst_cout", 64'(bus.cout), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check_stats("rst");
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_one(vecs[i], i);

    // Back-pressure: three pairs, out_ready dropped once the first result shows.
    drive(1'b1, 8'h12, 8'h34, 1'b0);
    @(negedge clk);
    check("bp_in_ready0", 64'(bus.in_ready), 64'd1);
    drive(1'b1, 8'h0F, 8'h01, 1'b1);
    @(negedge clk);
    check("bp_first_valid", 64'(bus.out_valid), 64'd1);
    bus.out_ready = 1'b0;
    drive(1'b1, 8'hFF, 8'h01, 1'b0);
    #1;
    check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d_valid", j), 64'(bus.out_valid), 64'd1);
      check($sformatf("bp_hold%0d_res", j), 64'({bus.cout, bus.sum}), 64'h046);
      check($sformatf("bp_hold%0d_in_ready", j), 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    check("bp_second_valid", 64'(bus.out_valid), 64'd1);
    check("bp_second_res", 64'({bus.cout, bus.sum}), 64'h00F);
    @(negedge clk);
    check("bp_third_valid", 64'(bus.out_valid), 64'd1);
    check("bp_third_res", 64'({bus.cout, bus.sum}), 64'h100);
    @(negedge clk);
    account(8'h12, 8'h34, 1'b0);
    account(8'h0F, 8'h01, 1'b1);
    account(8'hFF, 8'h01, 1'b0);
    check("bp_drained", 64'(bus.out_valid), 64'd0);
    check_stats("bp");

    // Reset with two operands in flight.
    drive(1'b1, 8'h0F, 8'h01, 1'b1);
    @(negedge clk);
    drive(1'b1, 8'h88, 8'h88, 1'b1);
    @(negedge clk);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    mdl_cnt = 16'h0000;
    mdl_sum = 32'h0000_0000;
    check("mrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("mrst_in_ready", 64'(bus.in_ready), 64'd1);
    check_stats("mrst");
    rst = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check($sformatf("mrst_no_stale%0d", j), 64'(bus.out_valid), 64'd0);
    end
    check_stats("mrst_after");

    // Drive err_cnt to 0xFFFD with unit-error results, then push past the limit.
    drive(1'b1, 8'h0F, 8'h01, 1'b1);
    repeat (65533) @(negedge clk);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    mdl_cnt = 16'hFFFD;
    mdl_sum = 32'd65533;
    check_stats("preload");
    drive(1'b1, 8'h0F, 8'h01, 1'b1);
    repeat (4) @(negedge clk);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    mdl_cnt = 16'hFFFF;
    mdl_sum = 32'd65537;
    check_stats("sat");

    // Clear coinciding with an output transfer of a mismatching result.
    drive(1'b1, 8'h38, 8'h18, 1'b1);
    @(negedge clk);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    check("clr_pre_valid", 64'(bus.out_valid), 64'd1);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    mdl_cnt = 16'h0000;
    mdl_sum = 32'h0000_0000;
    check("clr_post_valid", 64'(bus.out_valid), 64'd0);
    check_stats("clr");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/apx_pipe_adder.md
APX_PIPE_ADDER -- requirements
Module: apx_pipe_adder

Interface
REQ-001 Parameter N, default 8: operand and sum width in bits; legal range N >= 2.
REQ-002 Parameter K, default 4: number of approximate LSBs; legal range 0..N; K=0 gives an exact adder.
REQ-003 Parameter S, default 2: pipeline register stages; legal range S >= 1.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-005 Port in_valid  in  1  operand pair present.
REQ-006 Port in_ready  out  1  block accepts the operand pair this cycle.
REQ-007 Ports A, B  in  N  operands.
REQ-008 Port approx_en  in  1  1 = approximate mode, 0 = exact mode; sampled with operands.
REQ-009 Port out_valid  out  1  result present.
REQ-010 Port out_ready  in  1  downstream accepts the result.
REQ-011 Port sum  out  N  result.
REQ-012 Port cout  out  1  carry out of bit N-1.
REQ-013 Port stat_clr  in  1  clears the error statistics.
REQ-014 Port err_cnt  out  16  count of inexact results.
REQ-015 Port err_sum  out  32  accumulated absolute error distance.

Function
REQ-016 Approximate mode, low part: sum[K-1:0] SHALL be A[K-1:0] | B[K-1:0], bitwise.
REQ-017 Approximate mode, high part: sum[N-1:K] and cout SHALL be the exact sum A[N-1:K] + B[N-1:K] + (A[K-1] & B[K-1]); when K=0 the carry-in is 0.
REQ-018 Exact mode: {cout, sum} SHALL equal A + B, N+1 bits, with no truncation.
REQ-019 Transfer rules: input transfer = in_valid & in_ready; output transfer = out_valid & out_ready.
REQ-020 Pipeline advance: the pipeline SHALL advance when advance = !out_valid | out_ready; in_ready SHALL equal advance, combinationally.
REQ-021 On advance, every stage SHALL load from its predecessor, stage 0 loads the input transfer, and the valid bits shift along with the data; bubbles are not collapsed.
REQ-022 When the pipeline is not advancing, all stage registers SHALL hold, and sum, cout and out_valid SHALL stay stable until the output transfer.
REQ-023 Latency: with out_ready held at 1, a result SHALL appear exactly S cycles after its input transfer; throughput SHALL be 1 result per cycle.
REQ-024 The mode used for a result SHALL be the approx_en value captured with its operands; approx_en changes SHALL NOT affect operands already in flight.
REQ-025 Result order SHALL equal operand order; no result is dropped or duplicated.

Reset
REQ-026 While rst=1 at a clock edge, all valid bits, data registers, sum, cout, err_cnt and err_sum SHALL become 0.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight operands, and no result SHALL emerge for them.
REQ-028 During reset, in_ready SHALL be 1, following REQ-020 with out_valid=0; no input transfer is accepted on a cycle with rst=1.
REQ-029 Outputs SHALL be valid from the first cycle after rst deasserts.

Configuration
REQ-030 Macro APX_ERR_STATS_EN, when defined, SHALL compile in a parallel exact-sum pipeline of N+1 bits per stage and the statistics logic; this is the only configurable feature.
REQ-031 With APX_ERR_STATS_EN, each output transfer SHALL compare the exact sum with {cout, sum}; on a mismatch, err_cnt SHALL increment and err_sum SHALL add |exact - approx|.
REQ-032 With APX_ERR_STATS_EN, err_cnt and err_sum SHALL saturate at all-ones and not wrap.
REQ-033 With APX_ERR_STATS_EN, stat_clr=1 SHALL zero both counters on the next edge; on simultaneous stat_clr and output transfer, clear wins and both counters read 0.
REQ-034 Without APX_ERR_STATS_EN, err_cnt and err_sum SHALL be constant 0, stat_clr SHALL be ignored, and no exact-sum registers SHALL be present.

Verification (N=8, K=4, S=2, macro defined)
REQ-035 The bench SHALL apply A=0x0F, B=0x01, approx_en=1, out_ready=1 -> sum=0x0F and cout=0 two cycles later; err_cnt=1, err_sum=1.
REQ-036 The bench SHALL apply A=0x38, B=0x18, approx_en=1 -> sum=0x58, cout=0; err_cnt increments and err_sum increases by 8.
REQ-037 The bench SHALL apply A=0xFF, B=0x01, approx_en=0 -> sum=0x00, cout=1; counters unchanged.
REQ-038 The bench SHALL stream 3 pairs with out_ready=0 after the first result -> in_ready=0 while out_valid=1; results held stable; on releasing out_ready, all 3 emerge in order with no loss.
REQ-039 The bench SHALL assert rst with 2 operands in flight -> out_valid=0 the next cycle, no stale result afterwards, and counters read 0.
REQ-040 The bench SHALL preload err_cnt near 0xFFFF, then drive mismatches -> err_cnt stops at 0xFFFF; stat_clr together with a transfer -> err_cnt=0.
